data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem_pkg.sv | 34 +++
 rtl/data_mem_if.sv | 23 ++
 rtl/data_mem_align.sv | 26 ++
 rtl/data_mem.sv | 105 ++++++++++
 tb/tb_data_mem.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings and request-decode helpers for the data memory.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return 4'b0011 << lane;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Load/store request bus between the control unit and the data memory.
interface data_mem_if;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] mem_write;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] mem_read;
  logic        rd_valid;
  logic        err;
  logic        busy;

  modport master (
    output addr, rd_en, wr_en, mem_write, size, load_unsigned,
    input  mem_read, rd_valid, err, busy
  );

  modport slave (
    input  addr, rd_en, wr_en, mem_write, size, load_unsigned,
    output mem_read, rd_valid, err, busy
  );
endinterface

// File: rtl/data_mem_align.sv
// Load alignment: moves the addressed lane(s) to bit 0 and extends to 32 bits.
module data_mem_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    data    = word;
    case (size)
      SZ_BYTE: data = load_unsigned ? {24'h000000, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = load_unsigned ? {16'h0000, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable data memory with self-clearing init and 1-cycle registered loads.
//   state   | meaning
//   ST_INIT | clearing word[init_idx] each cycle, requests ignored, busy high
//   ST_IDLE | one load or store accepted per cycle
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] BYTES = 33'(DEPTH) << 2;

  state_e          state, state_nxt;
  logic [AW-1:0]   init_idx, init_idx_nxt;
  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic            idle, bad, wr_ok, rd_ok, err_nxt;
  logic [3:0]      mask;
  logic [31:0]     wdata, load_data;
  logic [31:0]     mem_read_q;
  logic            rd_valid_q, err_q;

  assign idx     = bus.addr[AW+1:2];
  assign lane    = bus.addr[1:0];
  assign idle    = (state == ST_IDLE);
  assign bad     = is_misaligned(bus.size, lane) || ({1'b0, bus.addr} >= BYTES);
  assign wr_ok   = idle && bus.wr_en && !bad;
  assign rd_ok   = idle && bus.rd_en && !bus.wr_en;
  assign err_nxt = idle && (bus.rd_en || bus.wr_en) && (bad || (bus.rd_en && bus.wr_en));
  assign mask    = lane_mask(bus.size, lane);

  always_comb begin
    wdata = bus.mem_write;
    case (bus.size)
      SZ_BYTE: wdata = {4{bus.mem_write[7:0]}};
      SZ_HALF: wdata = {2{bus.mem_write[15:0]}};
      default: wdata = bus.mem_write;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else begin
      state    <= state_nxt;
      init_idx <= init_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    if (state == ST_INIT) begin
      init_idx_nxt = init_idx + AW'(1);
      if (init_idx == AW'(DEPTH - 1)) state_nxt = ST_IDLE;
    end
  end

  // Storage is not reset directly; the INIT sweep clears it after every reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[init_idx] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < 4; i++) begin
          if (mask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  data_mem_align u_align (
    .word          (mem[idx]),
    .lane          (lane),
    .size          (bus.size),
    .load_unsigned (bus.load_unsigned),
    .data          (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      mem_read_q <= '0;
    end else begin
      rd_valid_q <= rd_ok;
      err_q      <= err_nxt;
      if (rd_ok) mem_read_q <= bad ? '0 : load_data;
    end
  end

  assign bus.mem_read = mem_read_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state == ST_INIT);

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: reference memory model plus response scoreboard.
module tb_data_mem;
  import data_mem_pkg::*;

  localparam int DEPTH = 64;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_if bus();

  data_mem #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  resp_t       sb[$];
  logic [31:0] model [DEPTH];
  logic [31:0] last_read;
  int          tests_run = 0;
  int          failed    = 0;

  task automatic drive_idle();
    bus.rd_en         = 1'b0;
    bus.wr_en         = 1'b0;
    bus.addr          = '0;
    bus.mem_write     = '0;
    bus.size          = SZ_WORD;
    bus.load_unsigned = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    last_read = '0;
  endtask

  // Reference behaviour for one request; also applies any store to the model.
  task automatic predict(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                         output resp_t r);
    logic        mis, oor, bad;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int          wi, ln;
    mis = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b11);
    oor = (a >= 32'(4 * DEPTH));
    bad = mis || oor;
    wi  = int'((a >> 2) & 32'(DEPTH - 1));
    ln  = int'(a[1:0]);
    w   = model[wi];
    r.valid = rd && !wr;
    r.err   = (rd || wr) && (bad || (rd && wr));
    r.data  = '0;
    if (rd && !wr && !bad) begin
      case (sz)
        2'b00: begin
          b = w[8*ln +: 8];
          r.data = uns ? {24'h0, b} : {{24{b[7]}}, b};
        end
        2'b01: begin
          h = w[8*ln +: 16];
          r.data = uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        default: r.data = w;
      endcase
    end
    if (wr && !bad) begin
      case (sz)
        2'b00:   model[wi][8*ln +: 8]  = wd[7:0];
        2'b01:   model[wi][8*ln +: 16] = wd[15:0];
        default: model[wi]             = wd;
      endcase
    end
  endtask

  // Drives one request for one cycle and checks the registered response.
  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                     input string name);
    resp_t exp;
    logic [31:0] want;
    predict(rd, wr, a, sz, uns, wd, exp);
    sb.push_back(exp);
    bus.rd_en = rd; bus.wr_en = wr; bus.addr = a;
    bus.size = sz; bus.load_unsigned = uns; bus.mem_write = wd;
    @(posedge clk); #1;
    drive_idle();
    exp = sb.pop_front();
    tests_run++;
    if (bus.rd_valid !== exp.valid) begin
      failed++;
      $display("FAIL %s rd_valid: got %b expected %b", name, bus.rd_valid, exp.valid);
    end
    tests_run++;
    if (bus.err !== exp.err) begin
      failed++;
      $display("FAIL %s err: got %b expected %b", name, bus.err, exp.err);
    end
    want = exp.valid ? exp.data : last_read;
    tests_run++;
    if (bus.mem_read !== want) begin
      failed++;
      $display("FAIL %s mem_read: got %h expected %h", name, bus.mem_read, want);
    end
    if (exp.valid) last_read = exp.data;
  endtask

  // Counts busy cycles after reset release; optionally pokes ignored requests.
  task automatic wait_init(input logic poke, output int cnt, output int stray);
    cnt = 0;
    stray = 0;
    while (bus.busy && cnt < DEPTH + 16) begin
      if (poke) begin
        bus.addr = 32'h4; bus.size = SZ_WORD; bus.mem_write = 32'hDEADBEEF;
        bus.rd_en = cnt[0]; bus.wr_en = !cnt[0];
      end
      @(posedge clk); #1;
      cnt++;
      if (bus.rd_valid || bus.err) stray++;
    end
    drive_idle();
  endtask

  task automatic test_reset();
    int cnt, stray;
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b1) begin failed++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
    tests_run++;
    if (bus.rd_valid !== 1'b0) begin failed++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
    tests_run++;
    if (bus.err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    tests_run++;
    if (bus.mem_read !== 32'h0) begin failed++; $display("FAIL reset_mem_read: got %h expected 0", bus.mem_read); end
    rst = 1'b0;
    wait_init(1'b1, cnt, stray);
    clear_model();
    tests_run++;
    if (cnt !== DEPTH) begin failed++; $display("FAIL init_busy_cycles: got %0d expected %0d", cnt, DEPTH); end
    tests_run++;
    if (stray !== 0) begin failed++; $display("FAIL init_ignores_requests: got %0d responses expected 0", stray); end
  endtask

  task automatic test_first_read();
    req(1, 0, 32'h0, SZ_WORD, 0, 0, "lw_0_after_init");
    tests_run++;
    if (bus.mem_read !== 32'h0) begin failed++; $display("FAIL lw_0_value: got %h expected 00000000", bus.mem_read); end
    req(1, 0, 32'h4, SZ_WORD, 0, 0, "lw_4_no_init_write");
  endtask

  task automatic test_sign_ext();
    req(0, 1, 32'h10, SZ_WORD, 0, 32'h800080F0, "sw_0x10");
    req(1, 0, 32'h10, SZ_BYTE, 0, 0, "lb_0x10");
    tests_run++;
    if (bus.mem_read !== 32'hFFFFFFF0) begin failed++; $display("FAIL lb_value: got %h expected FFFFFFF0", bus.mem_read); end
    req(1, 0, 32'h10, SZ_BYTE, 1, 0, "lbu_0x10");
    tests_run++;
    if (bus.mem_read !== 32'h000000F0) begin failed++; $display("FAIL lbu_value: got %h expected 000000F0", bus.mem_read); end
    req(1, 0, 32'h12, SZ_HALF, 0, 0, "lh_0x12");
    tests_run++;
    if (bus.mem_read !== 32'hFFFF8000) begin failed++; $display("FAIL lh_value: got %h expected FFFF8000", bus.mem_read); end
    req(1, 0, 32'h12, SZ_HALF, 1, 0, "lhu_0x12");
    tests_run++;
    if (bus.mem_read !== 32'h00008000) begin failed++; $display("FAIL lhu_value: got %h expected 00008000", bus.mem_read); end
    req(1, 0, 32'h11, SZ_BYTE, 1, 0, "lbu_0x11");
    req(1, 0, 32'h13, SZ_BYTE, 0, 0, "lb_0x13");
  endtask

  task automatic test_partial_write();
    req(0, 1, 32'h20, SZ_WORD, 0, 32'h11223344, "sw_0x20");
    req(0, 1, 32'h21, SZ_BYTE, 0, 32'hFFFFFFAA, "sb_0x21");
    req(1, 0, 32'h20, SZ_WORD, 0, 0, "lw_0x20");
    tests_run++;
    if (bus.mem_read !== 32'h1122AA44) begin failed++; $display("FAIL sb_merge: got %h expected 1122AA44", bus.mem_read); end
    req(0, 1, 32'h26, SZ_HALF, 0, 32'h1234BEEF, "sh_0x26");
    req(1, 0, 32'h24, SZ_WORD, 0, 0, "lw_0x24");
  endtask

  task automatic test_misaligned();
    req(1, 0, 32'h23, SZ_HALF, 0, 0, "lh_0x23");
    tests_run++;
    if (bus.err !== 1'b1 || bus.rd_valid !== 1'b1 || bus.mem_read !== 32'h0) begin
      failed++;
      $display("FAIL lh_misaligned: got err=%b rd_valid=%b data=%h expected 1 1 00000000",
               bus.err, bus.rd_valid, bus.mem_read);
    end
    req(0, 1, 32'h21, SZ_HALF, 0, 32'h0000FFFF, "sh_0x21");
    req(0, 1, 32'h22, SZ_WORD, 0, 32'hFFFFFFFF, "sw_0x22");
    req(0, 1, 32'h20, SZ_RSVD, 0, 32'hFFFFFFFF, "store_rsvd");
    req(1, 0, 32'h20, SZ_RSVD, 0, 0, "load_rsvd");
    req(1, 0, 32'h20, SZ_WORD, 0, 0, "lw_0x20_unchanged");
    tests_run++;
    if (bus.mem_read !== 32'h1122AA44) begin failed++; $display("FAIL misaligned_no_write: got %h expected 1122AA44", bus.mem_read); end
  endtask

  task automatic test_out_of_range();
    req(0, 1, 32'(4 * DEPTH), SZ_WORD, 0, 32'hFFFFFFFF, "sw_oor");
    tests_run++;
    if (bus.err !== 1'b1) begin failed++; $display("FAIL sw_oor_err: got %b expected 1", bus.err); end
    req(0, 1, 32'(4 * DEPTH + 5), SZ_BYTE, 0, 32'h5A, "sb_oor");
    req(1, 0, 32'(4 * DEPTH), SZ_WORD, 0, 0, "lw_oor");
    req(1, 0, 32'hFFFFFFFC, SZ_WORD, 0, 0, "lw_top");
    for (int i = 0; i < DEPTH; i++) req(1, 0, 32'(4 * i), SZ_WORD, 0, 0, "sweep_after_oor");
  endtask

  task automatic test_rd_wr_both();
    req(1, 1, 32'h8, SZ_WORD, 0, 32'h5, "rdwr_sw_0x8");
    tests_run++;
    if (bus.err !== 1'b1 || bus.rd_valid !== 1'b0) begin
      failed++;
      $display("FAIL rdwr_flags: got err=%b rd_valid=%b expected 1 0", bus.err, bus.rd_valid);
    end
    req(1, 0, 32'h8, SZ_WORD, 0, 0, "lw_0x8");
    tests_run++;
    if (bus.mem_read !== 32'h5) begin failed++; $display("FAIL rdwr_write_done: got %h expected 00000005", bus.mem_read); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    logic [1:0]  sz;
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if (sz == SZ_BYTE) a = a + 32'($urandom_range(0, 3));
      if (sz == SZ_HALF) a = a + (32'($urandom_range(0, 1)) << 1);
      if ($urandom_range(0, 7) == 0) a = a + 32'h1;
      d = $urandom;
      case ($urandom_range(0, 2))
        0: req(0, 1, a, sz, 0, d, "b2b_store");
        1: req(1, 0, a, sz, 1'($urandom_range(0, 1)), 0, "b2b_load");
        default: begin
          req(0, 1, a, sz, 0, d, "b2b_store_then");
          req(1, 0, a, sz, 1'($urandom_range(0, 1)), 0, "b2b_load_next");
        end
      endcase
    end
    req(0, 0, 32'h0, SZ_WORD, 0, 0, "hold_1");
    req(0, 0, 32'h4, SZ_WORD, 0, 0, "hold_2");
  endtask

  task automatic test_reset_mid();
    int cnt, stray;
    logic [31:0] addrs [6];
    addrs = '{32'h8, 32'h10, 32'h20, 32'h24, 32'h30, 32'h3C};
    req(0, 1, 32'h30, SZ_WORD, 0, 32'hCAFEF00D, "sw_0x30");
    req(0, 1, 32'h3C, SZ_WORD, 0, 32'h0BADBEEF, "sw_0x3C");
    req(1, 0, 32'h30, SZ_WORD, 0, 0, "lw_0x30");
    rst = 1'b1;
    bus.rd_en = 1'b1; bus.addr = 32'h30; bus.size = SZ_WORD;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    tests_run++;
    if (bus.rd_valid !== 1'b0) begin failed++; $display("FAIL read_in_reset: got rd_valid=%b expected 0", bus.rd_valid); end
    tests_run++;
    if (bus.mem_read !== 32'h0) begin failed++; $display("FAIL reset_clears_mem_read: got %h expected 0", bus.mem_read); end
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init(1'b0, cnt, stray);
    clear_model();
    tests_run++;
    if (cnt !== DEPTH) begin failed++; $display("FAIL reinit_busy_cycles: got %0d expected %0d", cnt, DEPTH); end
    foreach (addrs[i]) begin
      req(1, 0, addrs[i], SZ_WORD, 0, 0, "lw_after_reset");
      tests_run++;
      if (bus.mem_read !== 32'h0) begin failed++; $display("FAIL cleared_after_reset: addr %h got %h expected 0", addrs[i], bus.mem_read); end
    end
  endtask

  initial begin
    drive_idle();
    clear_model();
    test_reset();
    test_first_read();
    test_sign_ext();
    test_partial_write();
    test_misaligned();
    test_out_of_range();
    test_rd_wr_both();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
